// File: rtl/clock_defs.sv
// Shared definitions for the digital clock: set-mode encodings, field limits
// and the hour stepping rule used by both the tick carry and SET_HOUR.
// Optional build macro: CLOCK_12H_EN selects 1..12 hours with a PM flag.
package clock_defs;

    localparam int TIME_W = 6;

    localparam logic [TIME_W-1:0] SEC_MAX     = 6'd59;
    localparam logic [TIME_W-1:0] MIN_MAX     = 6'd59;
    localparam logic [TIME_W-1:0] HOUR_MAX_24 = 6'd23;
    localparam logic [TIME_W-1:0] HOUR_MAX_12 = 6'd12;

`ifdef CLOCK_12H_EN
    localparam logic [TIME_W-1:0] HOUR_RESET = HOUR_MAX_12;
`else
    localparam logic [TIME_W-1:0] HOUR_RESET = 6'd0;
`endif

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_t;

    typedef struct packed {
        logic [TIME_W-1:0] hour;
        logic              pm;
    } hour_pm_t;

    // Next hour value. In 12-hour mode 11->12 flips AM/PM and 12->1 does not;
    // in 24-hour mode the PM flag passes through untouched (it stays 0).
    function automatic hour_pm_t hour_step(input logic [TIME_W-1:0] hour,
                                           input logic              pm);
        hour_pm_t res;
`ifdef CLOCK_12H_EN
        if (hour == HOUR_MAX_12) begin
            res.hour = 6'd1;
            res.pm   = pm;
        end else begin
            res.hour = hour + 6'd1;
            res.pm   = (hour == HOUR_MAX_12 - 6'd1) ? ~pm : pm;
        end
`else
        res.hour = (hour == HOUR_MAX_24) ? 6'd0 : hour + 6'd1;
        res.pm   = pm;
`endif
        return res;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a clean, clk-synchronous level input.
// The pulse is combinational from the registered history so the consuming
// logic acts on the same edge that first samples the level high.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    // One-cycle history of the input; cleared by the synchronous active-low reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) din_q <= 1'b0;
        else      din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/time_keeper.sv
// Timekeeping core: 1 s prescaler, sec/min/hour counters with carry and a
// button-driven set mode (RUN -> SET_HOUR -> SET_MIN -> RUN).
// Optional build macro: CLOCK_12H_EN (12-hour display with PM indicator).
module time_keeper
    import clock_defs::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [TIME_W-1:0] sec_val,
    output logic [TIME_W-1:0] min_val,
    output logic [TIME_W-1:0] hour_val,
    output logic [1:0]        mode,
    output logic              sec_tick,
    output logic              pm
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    mode_t            state;
    mode_t            state_next;
    logic [CNT_W-1:0] presc;
    logic             pm_q;
    logic             mode_edge;
    logic             inc_edge;

    rise_detect u_mode_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_mode),
        .rise (mode_edge)
    );

    rise_detect u_inc_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_inc),
        .rise (inc_edge)
    );

    // Set-mode state register.
    always_ff @(posedge clk) begin
        if (!rst) state <= MODE_RUN;
        else      state <= state_next;
    end

    // Next-state logic: every mode button edge advances one step; 11 recovers to RUN.
    // NOTE: defaulting state_next first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            MODE_RUN:      if (mode_edge) state_next = MODE_SET_HOUR;
            MODE_SET_HOUR: if (mode_edge) state_next = MODE_SET_MIN;
            MODE_SET_MIN:  if (mode_edge) state_next = MODE_RUN;
            default:       state_next = MODE_RUN;
        endcase
    end

    // Prescaler, time counters and tick pulse. A mode edge always wins over inc.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc    <= '0;
            sec_val  <= '0;
            min_val  <= '0;
            hour_val <= HOUR_RESET;
            pm_q     <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            case (state)
                MODE_RUN: begin
                    if (mode_edge) begin
                        // Leaving for SET_HOUR: restart the second from zero.
                        presc   <= '0;
                        sec_val <= '0;
                    end else if (presc == TICK_LAST) begin
                        presc    <= '0;
                        sec_tick <= 1'b1;
                        if (sec_val == SEC_MAX) begin
                            sec_val <= '0;
                            if (min_val == MIN_MAX) begin
                                min_val          <= '0;
                                {hour_val, pm_q} <= hour_step(hour_val, pm_q);
                            end else begin
                                min_val <= min_val + 6'd1;
                            end
                        end else begin
                            sec_val <= sec_val + 6'd1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                MODE_SET_HOUR: begin
                    presc   <= '0;
                    sec_val <= '0;
                    if (inc_edge && !mode_edge)
                        {hour_val, pm_q} <= hour_step(hour_val, pm_q);
                end
                MODE_SET_MIN: begin
                    presc   <= '0;
                    sec_val <= '0;
                    if (inc_edge && !mode_edge)
                        min_val <= (min_val == MIN_MAX) ? 6'd0 : min_val + 6'd1;
                end
                default: begin
                    presc   <= '0;
                    sec_val <= '0;
                end
            endcase
        end
    end

    assign mode = state;
    assign pm   = pm_q;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper with TICK_DIV=4: a vector table for the
// cycle-by-cycle start-up and set-mode behaviour, then directed sequences for
// held buttons, hour/minute wrap, tick latency, midnight rollover and reset.
// Optional build macro: CLOCK_12H_EN (expects 12-hour behaviour).
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] sec_val, min_val, hour_val;
    logic [1:0] mode;
    logic       sec_tick, pm;

    int compared   = 0;
    int mismatched = 0;

    // Reference time model.
    int eh, em, es, epm;

`ifdef CLOCK_12H_EN
    localparam int HR0     = 12;
    localparam int SET_TGT = 10;
    localparam int ROLL_H  = 11;
`else
    localparam int HR0     = 0;
    localparam int SET_TGT = 22;
    localparam int ROLL_H  = 23;
`endif

    typedef struct {
        logic bm;
        logic bi;
        int   s;
        int   m;
        int   h;
        int   md;
        int   tk;
    } vec_t;

    vec_t vecs[17];

    time_keeper #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_val  (sec_val),
        .min_val  (min_val),
        .hour_val (hour_val),
        .mode     (mode),
        .sec_tick (sec_tick),
        .pm       (pm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string name);
        check({name, ".sec"},  int'(sec_val),  es);
        check({name, ".min"},  int'(min_val),  em);
        check({name, ".hour"}, int'(hour_val), eh);
        check({name, ".pm"},   int'(pm),       epm);
    endtask

    // Model of one hour increment (tick carry or SET_HOUR inc).
    task automatic hour_inc_m();
`ifdef CLOCK_12H_EN
        if (eh == 11) begin
            eh  = 12;
            epm = epm ^ 1;
        end else if (eh == 12) begin
            eh = 1;
        end else begin
            eh = eh + 1;
        end
`else
        eh = (eh == 23) ? 0 : eh + 1;
`endif
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        step();
        btn_inc = 1'b0;
        step();
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    initial begin
        int n;

        //             bm bi  s  m  h    md tk
        vecs[0]  = '{1'b0, 1'b0, 0, 0, HR0, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 0, 0, HR0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 0, 0, HR0, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1, 0, HR0, 0, 1};  // first tick, 4 cycles after release
        vecs[4]  = '{1'b1, 1'b0, 0, 0, HR0, 1, 0};  // SET_HOUR clears sec
        vecs[5]  = '{1'b1, 1'b0, 0, 0, HR0, 1, 0};  // held mode: no second edge
        vecs[6]  = '{1'b0, 1'b1, 0, 0, 1,   1, 0};  // inc visible next cycle
        vecs[7]  = '{1'b0, 1'b1, 0, 0, 1,   1, 0};
        vecs[8]  = '{1'b0, 1'b0, 0, 0, 1,   1, 0};
        vecs[9]  = '{1'b1, 1'b1, 0, 0, 1,   2, 0};  // collision: mode wins
        vecs[10] = '{1'b0, 1'b0, 0, 0, 1,   2, 0};
        vecs[11] = '{1'b0, 1'b1, 0, 1, 1,   2, 0};  // minute inc
        vecs[12] = '{1'b1, 1'b0, 0, 1, 1,   0, 0};  // back to RUN
        vecs[13] = '{1'b0, 1'b1, 0, 1, 1,   0, 0};  // inc ignored in RUN
        vecs[14] = '{1'b0, 1'b1, 0, 1, 1,   0, 0};
        vecs[15] = '{1'b0, 1'b1, 0, 1, 1,   0, 0};
        vecs[16] = '{1'b0, 1'b0, 1, 1, 1,   0, 1};  // tick 4 cycles after RUN re-entry

        // Reset held with buttons toggling.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_mode = i[0];
            btn_inc  = ~i[0];
            step();
            check("rst.sec",  int'(sec_val),  0);
            check("rst.min",  int'(min_val),  0);
            check("rst.hour", int'(hour_val), HR0);
            check("rst.mode", int'(mode),     0);
            check("rst.tick", int'(sec_tick), 0);
            check("rst.pm",   int'(pm),       0);
        end
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        rst      = 1'b1;

        for (int i = 0; i < 17; i++) begin
            btn_mode = vecs[i].bm;
            btn_inc  = vecs[i].bi;
            step();
            check($sformatf("vec%0d.sec", i),  int'(sec_val),  vecs[i].s);
            check($sformatf("vec%0d.min", i),  int'(min_val),  vecs[i].m);
            check($sformatf("vec%0d.hour", i), int'(hour_val), vecs[i].h);
            check($sformatf("vec%0d.mode", i), int'(mode),     vecs[i].md);
            check($sformatf("vec%0d.tick", i), int'(sec_tick), vecs[i].tk);
            check($sformatf("vec%0d.pm", i),   int'(pm),       0);
        end
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        es = 1; em = 1; eh = 1; epm = 0;

        // Enter SET_HOUR: seconds cleared.
        btn_mode = 1'b1;
        step();
        check("set.mode", int'(mode), 1);
        check("set.sec",  int'(sec_val), 0);
        btn_mode = 1'b0;
        step();
        es = 0;

        // Inc held for 10 cycles counts once.
        btn_inc = 1'b1;
        repeat (10) step();
        btn_inc = 1'b0;
        step();
        hour_inc_m();
        check_time("held_inc");

        // Walk up, then three pulses across the hour wrap.
        while (eh != SET_TGT) begin
            press_inc();
            hour_inc_m();
        end
        check_time("hour_tgt");
        for (int i = 0; i < 3; i++) begin
            press_inc();
            hour_inc_m();
            check_time($sformatf("hour_pulse%0d", i));
        end

        // Position the hour for the midnight/noon rollover (AM in 12-hour mode).
        while (!(eh == ROLL_H && epm == 0)) begin
            press_inc();
            hour_inc_m();
        end
        press_mode();
        check("setmin.mode", int'(mode), 2);

        // Minute wrap in SET_MIN does not carry into hours.
        while (em != 59) begin
            press_inc();
            em = em + 1;
        end
        check_time("min59");
        press_inc();
        em = 0;
        check_time("min_wrap");
        while (em != 59) begin
            press_inc();
            em = em + 1;
        end

        // Back to RUN: first tick exactly 4 cycles after the mode edge.
        btn_mode = 1'b1;
        step();
        check("run.mode", int'(mode), 0);
        btn_mode = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!sec_tick && n < 10);
        check("run.tick_latency", n, 4);
        es = 1;
        check_time("run.first_sec");

        // Count up to 59 seconds, then the rollover edge.
        repeat (57 * 4) step();
        es = 58;
        check_time("sec58");
        repeat (4) step();
        es = 59;
        check_time("sec59");
        repeat (3) step();
        check_time("pre_roll");
        check("pre_roll.tick", int'(sec_tick), 0);
        step();
        check("roll.tick", int'(sec_tick), 1);
        es = 0;
        em = 0;
        hour_inc_m();
        check_time("roll");

`ifdef CLOCK_12H_EN
        // 12:59:59 PM -> 01:00:00 with PM held.
        press_mode();
        press_mode();
        es = 0;
        while (em != 59) begin
            press_inc();
            em = em + 1;
        end
        press_mode();
        check("pm_run.mode", int'(mode), 0);
        repeat (4 * 59 - 1) step();
        es = 59;
        check_time("pm_pre");
        repeat (4) step();
        es = 0;
        em = 0;
        hour_inc_m();
        check_time("pm_roll");
`endif

        // Reset asserted while in SET_HOUR overrides everything.
        btn_mode = 1'b1;
        step();
        check("mid.mode", int'(mode), 1);
        btn_mode = 1'b0;
        rst = 1'b0;
        step();
        es = 0; em = 0; eh = HR0; epm = 0;
        check_time("mid_rst");
        check("mid_rst.mode", int'(mode), 0);
        check("mid_rst.tick", int'(sec_tick), 0);
        rst = 1'b1;
        step();
        check("post_rst.mode", int'(mode), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
